// File: rtl/dut_driver.sv
// Drives stimulus vectors onto the DUT pins, waits a programmable settle time,
// then samples the synchronised DUT outputs and writes the masked response.
module dut_driver #(
    parameter logic [23:0] DEFAULT_MASK   = 24'hFFFFFF,
    parameter logic [7:0]  DEFAULT_SETTLE = 8'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] sfifo_data,
    output logic        sfifo_rdreq,
    input  logic        sfifo_rdempty,
    input  logic [31:0] dififo_data,
    output logic        dififo_rdreq,
    input  logic        dififo_rdempty,
    output logic [23:0] rfifo_data,
    output logic        rfifo_wrreq,
    input  logic        rfifo_wrfull,
    output logic [23:0] dut_in,
    input  logic [23:0] dut_out,
    output logic        busy,
    output logic [15:0] vec_count
);

    typedef enum logic [2:0] {
        IDLE, CFG_RD, CFG_LD, STIM_RD, STIM_LD, SETTLE, SAMPLE, WR_RES
    } state_t;

    state_t      state, state_nx;
    logic [23:0] mask;
    logic [7:0]  settle;
    logic [8:0]  cnt;
    logic [23:0] dut_out_s1, dut_out_s2;
    logic        wrreq_nx;

    assign sfifo_rdreq  = (state == STIM_RD);
    assign dififo_rdreq = (state == CFG_RD);
    assign busy         = (state != IDLE);

    // The write strobe is registered, so the full flag is judged one cycle
    // ahead of the write; WR_RES exits on the cycle the strobe is high.
    assign wrreq_nx = ((state == SAMPLE) || (state == WR_RES && !rfifo_wrreq))
                      && !rfifo_wrfull;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (!sfifo_rdempty)       state_nx = STIM_RD;
                else if (!dififo_rdempty) state_nx = CFG_RD;
            end
            CFG_RD:  state_nx = CFG_LD;
            CFG_LD:  state_nx = IDLE;
            STIM_RD: state_nx = STIM_LD;
            STIM_LD: state_nx = SETTLE;
            SETTLE:  if (cnt == 9'd0) state_nx = SAMPLE;
            SAMPLE:  state_nx = WR_RES;
            WR_RES:  if (rfifo_wrreq) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mask        <= DEFAULT_MASK;
            settle      <= DEFAULT_SETTLE;
            cnt         <= 9'd0;
            dut_in      <= 24'd0;
            dut_out_s1  <= 24'd0;
            dut_out_s2  <= 24'd0;
            rfifo_data  <= 24'd0;
            rfifo_wrreq <= 1'b0;
            vec_count   <= 16'd0;
        end else begin
            state       <= state_nx;
            dut_out_s1  <= dut_out;
            dut_out_s2  <= dut_out_s1;
            rfifo_wrreq <= wrreq_nx;
            case (state)
                CFG_LD: begin
                    mask   <= dififo_data[23:0];
                    settle <= dififo_data[31:24];
                end
                STIM_LD: begin
                    dut_in <= sfifo_data;
                    // +2 covers the synchroniser depth on top of the settle time
                    cnt    <= {1'b0, settle} + 9'd2;
                end
                SETTLE:  if (cnt != 9'd0) cnt <= cnt - 9'd1;
                SAMPLE:  rfifo_data <= dut_out_s2 & mask;
                WR_RES:  if (rfifo_wrreq) vec_count <= vec_count + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dut_driver.sv
// Directed bench for dut_driver: FIFO models around the block, DUT pins looped back.
module tb_dut_driver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [23:0] sfifo_data = 24'd0;
    logic        sfifo_rdreq;
    logic        sfifo_rdempty = 1'b1;
    logic [31:0] dififo_data = 32'd0;
    logic        dififo_rdreq;
    logic        dififo_rdempty = 1'b1;
    logic [23:0] rfifo_data;
    logic        rfifo_wrreq;
    logic        rfifo_wrfull;
    logic [23:0] dut_in;
    logic [23:0] dut_out;
    logic        busy;
    logic [15:0] vec_count;

    dut_driver dut (
        .clock(clock), .reset_n(reset_n),
        .sfifo_data(sfifo_data), .sfifo_rdreq(sfifo_rdreq), .sfifo_rdempty(sfifo_rdempty),
        .dififo_data(dififo_data), .dififo_rdreq(dififo_rdreq), .dififo_rdempty(dififo_rdempty),
        .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .vec_count(vec_count)
    );

    always #5 clock = ~clock;
    assign dut_out = dut_in;

    logic [23:0] sq[$];
    logic [31:0] dq[$];
    logic [23:0] rq_data[$];
    int          rq_lat[$];
    int          cyc = 0, rd_cyc = 0, rd_cnt = 0;
    int          tests = 0, fails = 0;

    // Normal-mode FIFO models: data appears the cycle after the read strobe.
    always @(posedge clock) begin
        logic [23:0] s;
        logic [31:0] d;
        cyc <= cyc + 1;
        if (sfifo_rdreq && sq.size() > 0) begin
            s = sq.pop_front();
            sfifo_data <= s;
            rd_cyc <= cyc;
            rd_cnt <= rd_cnt + 1;
        end
        if (dififo_rdreq && dq.size() > 0) begin
            d = dq.pop_front();
            dififo_data <= d;
        end
        if (rfifo_wrreq) begin
            rq_data.push_back(rfifo_data);
            rq_lat.push_back(cyc - rd_cyc);
        end
    end

    always @(negedge clock) begin
        sfifo_rdempty  <= (sq.size() == 0);
        dififo_rdempty <= (dq.size() == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_resp(input int n, input string name);
        int b;
        b = 0;
        while (rq_data.size() < n && b < 400) begin
            @(negedge clock);
            b++;
        end
        if (rq_data.size() < n) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout, got %0d responses expected %0d", name, rq_data.size(), n);
        end
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        @(negedge clock);
        while (busy && b < 400) begin
            @(negedge clock);
            b++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        bit          use_cfg;
        logic [31:0] cfg;
        logic [23:0] stim;
        logic [23:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t tbl[5];
    int   exp_vc;
    int   rd0;

    initial begin
        tbl[0] = '{1'b0, 32'h0,         24'hA5A5A5, 24'hA5A5A5, 10};
        tbl[1] = '{1'b1, 32'h00_0000FF, 24'h123456, 24'h000056, 6};
        tbl[2] = '{1'b1, 32'h02_F0F0F0, 24'hFFFFFF, 24'hF0F0F0, 8};
        tbl[3] = '{1'b1, 32'h00_FFFFFF, 24'h000000, 24'h000000, 6};
        tbl[4] = '{1'b1, 32'h04_FFFFFF, 24'h5A5A5A, 24'h5A5A5A, 10};

        reset_n = 1'b0;
        rfifo_wrfull = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_dut_in", {8'd0, dut_in}, 32'd0);
        reset_n = 1'b1;
        repeat (100) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sfifo_rdreq", {31'd0, sfifo_rdreq}, 32'd0);
        chk("rst_dififo_rdreq", {31'd0, dififo_rdreq}, 32'd0);
        chk("rst_rfifo_wrreq", {31'd0, rfifo_wrreq}, 32'd0);
        chk("rst_dut_in_idle", {8'd0, dut_in}, 32'd0);
        chk("rst_rfifo_data", {8'd0, rfifo_data}, 32'd0);
        chk("rst_vec_count", {16'd0, vec_count}, 32'd0);

        // Table: optional config, then one looped-back vector
        exp_vc = 0;
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].use_cfg) begin
                dq.push_back(tbl[i].cfg);
                repeat (6) @(negedge clock);
                chk($sformatf("tbl%0d_cfg_taken", i), dq.size(), 32'd0);
                wait_idle();
            end
            rq_data.delete();
            rq_lat.delete();
            sq.push_back(tbl[i].stim);
            wait_resp(1, $sformatf("tbl%0d_resp", i));
            exp_vc++;
            if (rq_data.size() > 0) begin
                chk($sformatf("tbl%0d_data", i), {8'd0, rq_data[0]}, {8'd0, tbl[i].exp_data});
                chk($sformatf("tbl%0d_latency", i), rq_lat[0], tbl[i].exp_lat);
            end
            chk($sformatf("tbl%0d_vec_count", i), {16'd0, vec_count}, exp_vc);
            chk($sformatf("tbl%0d_dut_in_hold", i), {8'd0, dut_in}, {8'd0, tbl[i].stim});
            wait_idle();
        end

        // Stimulus beats config: both vectors use settle=4, config lands afterwards
        rq_data.delete();
        rq_lat.delete();
        sq.push_back(24'h0F0F0F);
        dq.push_back(32'h10_FFFFFF);
        sq.push_back(24'hF0F0F0);
        wait_resp(1, "prio_resp1");
        chk("prio_cfg_pending", dq.size(), 32'd1);
        wait_resp(2, "prio_resp2");
        if (rq_data.size() >= 2) begin
            chk("prio_data0", {8'd0, rq_data[0]}, 32'h0F0F0F);
            chk("prio_lat0", rq_lat[0], 32'd10);
            chk("prio_data1", {8'd0, rq_data[1]}, 32'hF0F0F0);
            chk("prio_lat1", rq_lat[1], 32'd10);
        end
        wait_idle();
        repeat (4) @(negedge clock);
        chk("prio_cfg_consumed", dq.size(), 32'd0);
        wait_idle();
        rq_data.delete();
        rq_lat.delete();
        sq.push_back(24'h3C3C3C);
        wait_resp(1, "prio_resp3");
        if (rq_lat.size() > 0) chk("prio_lat_settle16", rq_lat[0], 32'd22);
        exp_vc += 3;
        wait_idle();
        dq.push_back(32'h04_FFFFFF);
        repeat (6) @(negedge clock);
        wait_idle();

        // Backpressure across three queued vectors
        rq_data.delete();
        rq_lat.delete();
        rfifo_wrfull = 1'b1;
        rd0 = rd_cnt;
        sq.push_back(24'h111111);
        sq.push_back(24'h222222);
        sq.push_back(24'h333333);
        repeat (40) @(negedge clock);
        chk("bp_no_write", rq_data.size(), 32'd0);
        chk("bp_one_read", rd_cnt - rd0, 32'd1);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        rfifo_wrfull = 1'b0;
        wait_resp(3, "bp_resp");
        repeat (20) @(negedge clock);
        chk("bp_count", rq_data.size(), 32'd3);
        if (rq_data.size() >= 3) begin
            chk("bp_data0", {8'd0, rq_data[0]}, 32'h111111);
            chk("bp_data1", {8'd0, rq_data[1]}, 32'h222222);
            chk("bp_data2", {8'd0, rq_data[2]}, 32'h333333);
        end
        exp_vc += 3;
        chk("bp_vec_count", {16'd0, vec_count}, exp_vc);
        wait_idle();

        // Reset while a vector is settling
        rq_data.delete();
        rq_lat.delete();
        rd0 = rd_cnt;
        sq.push_back(24'hABCDEF);
        for (int b = 0; b < 50 && rd_cnt == rd0; b++) @(negedge clock);
        chk("rst_mid_popped", rd_cnt - rd0, 32'd1);
        repeat (3) @(negedge clock);
        chk("rst_mid_in_settle", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_wrreq", {31'd0, rfifo_wrreq}, 32'd0);
        chk("rst_mid_dut_in", {8'd0, dut_in}, 32'd0);
        chk("rst_mid_vec_count", {16'd0, vec_count}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        sq.push_back(24'h765432);
        sq.push_back(24'h89ABCD);
        wait_resp(2, "rst_mid_resp");
        repeat (30) @(negedge clock);
        chk("rst_mid_count", rq_data.size(), 32'd2);
        if (rq_data.size() >= 2) begin
            chk("rst_mid_data0", {8'd0, rq_data[0]}, 32'h765432);
            chk("rst_mid_data1", {8'd0, rq_data[1]}, 32'h89ABCD);
            chk("rst_mid_lat0", rq_lat[0], 32'd10);
        end
        chk("rst_mid_vec_count2", {16'd0, vec_count}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
